// File: rtl/hazard_pkg.sv
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LSTALL = 2'd1,
    MWAIT  = 2'd2
  } hz_state_e;

  localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/hazard_reg_match.sv
module hazard_reg_match
  import hazard_pkg::*;
#(
  parameter int unsigned W = 5
) (
  input  logic         uses,
  input  logic [W-1:0] src,
  input  logic [W-1:0] rd,
  output logic         match
);

  assign match = uses && (src == rd) && (rd != W'(ZERO_REG));

endmodule

// File: rtl/hazard_stall_controller.sv
module hazard_stall_controller
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned LOAD_LAT   = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  ID_EX_MemRead,
  input  logic                  ID_EX_RegWrite,
  input  logic [REG_ADDR_W-1:0] ID_EX_RegisterRd,
  input  logic                  EX_MEM_MemRead,
  input  logic [REG_ADDR_W-1:0] EX_MEM_RegisterRd,
  input  logic [REG_ADDR_W-1:0] IF_ID_RegisterRs,
  input  logic [REG_ADDR_W-1:0] IF_ID_RegisterRt,
  input  logic                  IF_ID_UsesRs,
  input  logic                  IF_ID_UsesRt,
  input  logic                  IF_ID_Branch,
  input  logic                  BranchTaken,
  input  logic                  Jump,
  input  logic                  MemBusy,
  input  logic                  StatClear,
  output logic                  PCWrite,
  output logic                  IF_ID_Write,
  output logic                  ID_EX_Bubble,
  output logic                  IF_ID_Flush,
  output logic                  PipeFreeze,
  output logic [CNT_W-1:0]      StallCount
);

  localparam int unsigned CW = 3;

  hz_state_e        state_q, state_d;
  hz_state_e        saved_q, saved_d;
  hz_state_e        eff_state;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic m_rs_ex, m_rt_ex, m_rs_mem, m_rt_mem;
  logic lu, bh, stall;

  hazard_reg_match #(.W(REG_ADDR_W)) u_rs_ex (
    .uses (IF_ID_UsesRs), .src (IF_ID_RegisterRs), .rd (ID_EX_RegisterRd), .match (m_rs_ex)
  );
  hazard_reg_match #(.W(REG_ADDR_W)) u_rt_ex (
    .uses (IF_ID_UsesRt), .src (IF_ID_RegisterRt), .rd (ID_EX_RegisterRd), .match (m_rt_ex)
  );
  hazard_reg_match #(.W(REG_ADDR_W)) u_rs_mem (
    .uses (IF_ID_UsesRs), .src (IF_ID_RegisterRs), .rd (EX_MEM_RegisterRd), .match (m_rs_mem)
  );
  hazard_reg_match #(.W(REG_ADDR_W)) u_rt_mem (
    .uses (IF_ID_UsesRt), .src (IF_ID_RegisterRt), .rd (EX_MEM_RegisterRd), .match (m_rt_mem)
  );

  assign lu = ID_EX_MemRead && (m_rs_ex || m_rt_ex);
  assign bh = IF_ID_Branch &&
              ((ID_EX_RegWrite && (m_rs_ex || m_rt_ex)) ||
               (EX_MEM_MemRead && (m_rs_mem || m_rt_mem)));

  always_comb begin
    state_d      = state_q;
    saved_d      = saved_q;
    cnt_d        = cnt_q;
    stall        = 1'b0;
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    ID_EX_Bubble = 1'b0;
    IF_ID_Flush  = 1'b0;
    PipeFreeze   = 1'b0;

    // MWAIT with MemBusy low behaves as the saved state in the same cycle,
    // so the freeze lasts exactly as long as MemBusy.
    eff_state = (state_q == MWAIT) ? saved_q : state_q;

    if (MemBusy) begin
      PipeFreeze  = 1'b1;
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
      state_d     = MWAIT;
      saved_d     = (state_q == MWAIT) ? saved_q : state_q;
    end else begin
      state_d = eff_state;
      unique case (eff_state)
        RUN: begin
          if (lu || bh) begin
            stall = 1'b1;
            if (lu && (LOAD_LAT > 1)) begin
              state_d = LSTALL;
              cnt_d   = CW'(LOAD_LAT - 1);
            end
          end else if ((BranchTaken && IF_ID_Branch) || Jump) begin
            IF_ID_Flush = 1'b1;
          end
        end
        LSTALL: begin
          stall = 1'b1;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end

    if (stall) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Bubble = 1'b1;
    end

    stall_cnt_d = stall_cnt_q;
    if (StatClear)                       stall_cnt_d = '0;
    else if (stall && !(&stall_cnt_q))   stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= RUN;
      saved_q     <= RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      saved_q     <= saved_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;

endmodule

// File: doc/hazard_stall_controller.md
HAZARD_STALL_CONTROLLER -- requirements
Module: hazard_stall_controller

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5, register-specifier width.
REQ-002 SHALL have parameter LOAD_LAT, default 1, legal 1..4, load-use stall cycles per detected hazard.
REQ-003 SHALL have parameter CNT_W, default 16, stall-statistics counter width.
REQ-004 SHALL have ports, one per line: name  direction  width  meaning.
- Clk  in  1  single clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- ID_EX_MemRead  in  1  instruction in EX is a load.
- ID_EX_RegWrite  in  1  instruction in EX writes a register.
- ID_EX_RegisterRd  in  REG_ADDR_W  EX destination, post RegDst mux.
- EX_MEM_MemRead  in  1  instruction in MEM is a load.
- EX_MEM_RegisterRd  in  REG_ADDR_W  MEM destination.
- IF_ID_RegisterRs  in  REG_ADDR_W  ID source rs.
- IF_ID_RegisterRt  in  REG_ADDR_W  ID source rt.
- IF_ID_UsesRs, IF_ID_UsesRt  in  1 each  ID instruction reads rs / rt.
- IF_ID_Branch  in  1  ID holds a branch resolved in ID.
- BranchTaken  in  1  ID branch resolved taken.
- Jump  in  1  ID holds a jump.
- MemBusy  in  1  data memory not ready; pipeline must freeze.
- StatClear  in  1  synchronous clear of StallCount.
- PCWrite  out  1  PC update enable.
- IF_ID_Write  out  1  IF/ID register write enable.
- ID_EX_Bubble  out  1  zero ID/EX control signals (insert bubble).
- IF_ID_Flush  out  1  clear IF/ID (squash fetched instruction).
- PipeFreeze  out  1  hold ID/EX, EX/MEM, MEM/WB unchanged.
- StallCount  out  CNT_W  saturating count of stall cycles.

Function
REQ-005 SHALL treat a source as matching only if its Uses bit is 1, specifier equals the producer Rd, and Rd != 0.
REQ-006 SHALL detect load-use hazard LU = ID_EX_MemRead and a source match on ID_EX_RegisterRd.
REQ-007 SHALL detect branch hazard BH = IF_ID_Branch and (a source match on ID_EX_RegisterRd with ID_EX_RegWrite, or a source match on EX_MEM_RegisterRd with EX_MEM_MemRead).
REQ-008 SHALL implement FSM states RUN, LSTALL, MWAIT; reset state RUN.
REQ-009 RUN: LU or BH SHALL assert stall combinationally that same cycle (PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1).
REQ-010 RUN with LU and LOAD_LAT>1 SHALL go to LSTALL, loading the down-counter with LOAD_LAT-1; LOAD_LAT=1 stays in RUN.
REQ-011 LSTALL SHALL assert stall outputs unconditionally, decrement the counter each cycle, and return to RUN on the cycle the counter reads 1.
REQ-012 Stall outputs SHALL total exactly LOAD_LAT consecutive cycles per LU; BH stalls SHALL re-evaluate each RUN cycle.
REQ-013 MemBusy=1 in any state SHALL force PipeFreeze=1, PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=0, IF_ID_Flush=0, and enter MWAIT, saving the prior state and counter.
REQ-014 MWAIT SHALL hold while MemBusy=1 and, the cycle after MemBusy falls, resume the saved state with the counter unchanged.
REQ-015 IF_ID_Flush SHALL be 1 for one cycle when in RUN, (BranchTaken and IF_ID_Branch) or Jump, and no stall or freeze is asserted that cycle.
REQ-016 Flush SHALL be suppressed while stalled; branch is re-presented after the stall.
REQ-017 StallCount SHALL increment on every cycle with PCWrite=0 due to LU/BH/LSTALL (not MemBusy), saturate at all-ones, and clear on StatClear; clear has priority.
REQ-018 With no hazard, busy, or flush: PCWrite=1, IF_ID_Write=1, other control outputs 0.

Reset
REQ-019 Reset low SHALL asynchronously force state RUN, counter 0, saved state RUN, StallCount 0.
REQ-020 During and after reset, outputs SHALL be PCWrite=1, IF_ID_Write=1, ID_EX_Bubble=0, IF_ID_Flush=0, PipeFreeze=0.
REQ-021 Reset mid-LSTALL or mid-MWAIT SHALL abandon the stall; the first cycle after release evaluates in RUN.

Structure
REQ-022 State encodings (RUN=0, LSTALL=1, MWAIT=2) and a zero-register constant SHALL live in shared package hazard_pkg.
REQ-023 Source matching SHALL use one sub-module, hazard_reg_match (uses, src, rd -> match), instantiated per source/producer pair.

Verification
REQ-024 LOAD_LAT=1: lw $t0 in EX (Rd=8), ID uses rs=8 -> exactly 1 stall cycle, Bubble=1, StallCount=1.
REQ-025 LOAD_LAT=3: same stimulus -> PCWrite=0 for exactly 3 cycles, state RUN->LSTALL->LSTALL->RUN, StallCount=3.
REQ-026 Rd=0 with ID_EX_MemRead=1, rs=0 -> no stall; beq rs=9 while EX writes 9 -> 1 stall, then BranchTaken -> Flush=1 one cycle.
REQ-027 MemBusy=1 for 4 cycles during LSTALL (LOAD_LAT=3, counter 2) -> PipeFreeze=1 x4, then 2 more stall cycles, StallCount=3.
REQ-028 Reset asserted during LSTALL -> outputs immediately PCWrite=1, StallCount=0; StallCount at all-ones plus stall -> stays all-ones.
